// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand selection ahead of the ALU.
// Define OPERAND_FWD_EN to enable MEM/WB forwarding and WB refresh of a held entry.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic [3:0]      in_alu_ctrl,
  input  logic            in_a_sel_pc,
  input  logic            in_b_sel_imm,
  input  logic            mem_we,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [3:0]      ALUcontrol,
  output logic [RA_W-1:0] out_rd_addr,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_pc
);

  logic            capture;
  logic [XLEN-1:0] rs1v;
  logic [XLEN-1:0] rs2v;
  logic            refresh_rs1;
  logic            refresh_rs2;

  // A flush always opens the input so the redirected-away beat is swallowed.
  assign in_ready = flush | ~out_valid | out_ready;
  assign capture  = in_valid & in_ready & ~flush;

  always_comb begin
    rs1v = in_rs1_data;
    rs2v = in_rs2_data;
`ifdef OPERAND_FWD_EN
    if (mem_we && mem_rd == in_rs1_addr)     rs1v = mem_data;
    else if (wb_we && wb_rd == in_rs1_addr)  rs1v = wb_data;
    if (mem_we && mem_rd == in_rs2_addr)     rs2v = mem_data;
    else if (wb_we && wb_rd == in_rs2_addr)  rs2v = wb_data;
`endif
    if (in_rs1_addr == '0) rs1v = '0;
    if (in_rs2_addr == '0) rs2v = '0;
  end

`ifdef OPERAND_FWD_EN
  logic [RA_W-1:0] rs1_addr_q;
  logic [RA_W-1:0] rs2_addr_q;
  logic            a_sel_pc_q;
  logic            b_sel_imm_q;

  // Only WB is snooped while holding; MEM hazards during a stall belong to the interlock.
  assign refresh_rs1 = out_valid & ~out_ready & ~flush & wb_we &
                       (wb_rd == rs1_addr_q) & (rs1_addr_q != '0);
  assign refresh_rs2 = out_valid & ~out_ready & ~flush & wb_we &
                       (wb_rd == rs2_addr_q) & (rs2_addr_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      a_sel_pc_q  <= 1'b0;
      b_sel_imm_q <= 1'b0;
    end else if (capture) begin
      rs1_addr_q  <= in_rs1_addr;
      rs2_addr_q  <= in_rs2_addr;
      a_sel_pc_q  <= in_a_sel_pc;
      b_sel_imm_q <= in_b_sel_imm;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd  = ^{mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data};
  assign refresh_rs1 = 1'b0;
  assign refresh_rs2 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      SrcA           <= '0;
      SrcB           <= '0;
      ALUcontrol     <= 4'b0000;
      out_rd_addr    <= '0;
      out_store_data <= '0;
      out_pc         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid      <= 1'b1;
      SrcA           <= in_a_sel_pc ? in_pc : rs1v;
      SrcB           <= in_b_sel_imm ? in_imm : rs2v;
      ALUcontrol     <= in_alu_ctrl;
      out_rd_addr    <= in_rd_addr;
      out_store_data <= rs2v;
      out_pc         <= in_pc;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
`ifdef OPERAND_FWD_EN
      if (refresh_rs1 && !a_sel_pc_q) SrcA <= wb_data;
      if (refresh_rs2) begin
        out_store_data <= wb_data;
        if (!b_sel_imm_q) SrcB <= wb_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: stimulus pushes expected beats, monitor pops on consume.
// Expected operand values depend on whether OPERAND_FWD_EN is defined.
module tb_id_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef struct {
    logic [XLEN-1:0] pc, rs1d, rs2d, imm;
    logic [RA_W-1:0] rs1a, rs2a, rda;
    logic [3:0]      alu;
    logic            asel, bsel;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] srca, srcb, store, pc;
    logic [RA_W-1:0] rd;
    logic [3:0]      alu;
  } exp_t;

  logic            clk, rst_n, flush, in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [RA_W-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0]      in_alu_ctrl;
  logic            in_a_sel_pc, in_b_sel_imm;
  logic            mem_we, wb_we;
  logic [RA_W-1:0] mem_rd, wb_rd;
  logic [XLEN-1:0] mem_data, wb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] SrcA, SrcB, out_store_data, out_pc;
  logic [3:0]      ALUcontrol;
  logic [RA_W-1:0] out_rd_addr;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   cyc = 0;
  exp_t expQ[$];
  int   consCyc[$];

  id_ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_ctrl(in_alu_ctrl), .in_a_sel_pc(in_a_sel_pc), .in_b_sel_imm(in_b_sel_imm),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUcontrol(ALUcontrol),
    .out_rd_addr(out_rd_addr), .out_store_data(out_store_data), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat the EX stage takes must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      consCyc.push_back(cyc);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_beat_srca", SrcA, 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("srca", SrcA, e.srca);
        checkOutput("srcb", SrcB, e.srcb);
        checkOutput("store_data", out_store_data, e.store);
        checkOutput("alu_ctrl", ALUcontrol, e.alu);
        checkOutput("rd_addr", out_rd_addr, e.rd);
        checkOutput("pc", out_pc, e.pc);
      end
    end
  end

  // Presents one beat until accepted; on acceptance optionally pushes its expected result.
  task automatic applyStimulus(input vec_t v, input logic [XLEN-1:0] srca,
                               input logic [XLEN-1:0] srcb, input logic [XLEN-1:0] store,
                               input bit track);
    exp_t e;
    bit   rdy;
    in_valid = 1'b1;
    in_pc = v.pc; in_rs1_data = v.rs1d; in_rs2_data = v.rs2d; in_imm = v.imm;
    in_rs1_addr = v.rs1a; in_rs2_addr = v.rs2a; in_rd_addr = v.rda;
    in_alu_ctrl = v.alu; in_a_sel_pc = v.asel; in_b_sel_imm = v.bsel;
    rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
    end
    #1;
    if (!rdy) checkOutput("accept_timeout", 64'd0, 64'd1);
    else if (track) begin
      e.srca = srca; e.srcb = srcb; e.store = store;
      e.pc = v.pc; e.rd = v.rda; e.alu = v.alu;
      expQ.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [XLEN-1:0] pc, rs1d, rs2d, imm,
                              input logic [RA_W-1:0] rs1a, rs2a, rda,
                              input logic [3:0] alu, input logic asel, bsel);
    vec_t v;
    v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm;
    v.rs1a = rs1a; v.rs2a = rs2a; v.rda = rda; v.alu = alu; v.asel = asel; v.bsel = bsel;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startN;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0; in_alu_ctrl = '0;
    in_a_sel_pc = 1'b0; in_b_sel_imm = 1'b0;
    mem_we = 1'b0; mem_rd = '0; mem_data = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;

    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_srca", SrcA, 0);
    checkOutput("reset_srcb", SrcB, 0);
    checkOutput("reset_alu", ALUcontrol, 0);
    checkOutput("reset_store", out_store_data, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic register operands.
    applyStimulus(mk(32'h100, 32'd7, 32'd3, 32'h0, 5, 6, 10, 4'b0001, 0, 0), 32'd7, 32'd3, 32'd3, 1);
    idleCycles(1);
    checkOutput("consumed_valid_drop", out_valid, 0);
    checkOutput("consumed_data_hold", SrcA, 32'd7);

    // MEM beats WB; then WB alone; regfile value 0x11 when forwarding is off.
    mem_we = 1; mem_rd = 5; mem_data = 32'h100; wb_we = 1; wb_rd = 5; wb_data = 32'h200;
`ifdef OPERAND_FWD_EN
    applyStimulus(mk(32'h104, 32'h11, 32'h22, 32'h44, 5, 2, 1, 4'b0010, 0, 1), 32'h100, 32'h44, 32'h22, 1);
    mem_we = 0;
    applyStimulus(mk(32'h108, 32'h11, 32'h22, 32'h44, 5, 2, 1, 4'b0011, 0, 1), 32'h200, 32'h44, 32'h22, 1);
`else
    applyStimulus(mk(32'h104, 32'h11, 32'h22, 32'h44, 5, 2, 1, 4'b0010, 0, 1), 32'h11, 32'h44, 32'h22, 1);
    mem_we = 0;
    applyStimulus(mk(32'h108, 32'h11, 32'h22, 32'h44, 5, 2, 1, 4'b0011, 0, 1), 32'h11, 32'h44, 32'h22, 1);
`endif

    // x0 never forwards; PC select on A.
    mem_we = 1; mem_rd = 0; mem_data = 32'hFFFF_FFFF; wb_we = 1; wb_rd = 0; wb_data = 32'hABC;
    applyStimulus(mk(32'h10C, 32'h1234, 32'h5678, 32'h0, 0, 0, 2, 4'b0100, 0, 0), 32'h0, 32'h0, 32'h0, 1);
    mem_we = 0; wb_we = 0;
    applyStimulus(mk(32'h400, 32'h33, 32'h66, 32'h8, 3, 4, 3, 4'b0101, 1, 1), 32'h400, 32'h8, 32'h66, 1);
    idleCycles(2);

    // Hold with WB refresh of rs2; MEM must not be snooped.
    out_ready = 0;
`ifdef OPERAND_FWD_EN
    applyStimulus(mk(32'h200, 32'h10, 32'h90, 32'h0, 1, 9, 4, 4'b0110, 0, 0), 32'h10, 32'h55, 32'h55, 1);
`else
    applyStimulus(mk(32'h200, 32'h10, 32'h90, 32'h0, 1, 9, 4, 4'b0110, 0, 0), 32'h10, 32'h90, 32'h90, 1);
`endif
    in_rs1_data = 32'hBAD; in_rs2_data = 32'hBAD;
    wb_we = 1; wb_rd = 9; wb_data = 32'h55;
    mem_we = 1; mem_rd = 1; mem_data = 32'h77;
    @(posedge clk); #1;
`ifdef OPERAND_FWD_EN
    checkOutput("hold_refresh_srcb", SrcB, 32'h55);
`else
    checkOutput("hold_refresh_srcb", SrcB, 32'h90);
`endif
    checkOutput("hold_no_mem_snoop", SrcA, 32'h10);
    checkOutput("hold_out_valid", out_valid, 1);
    checkOutput("hold_in_ready", in_ready, 0);
    wb_we = 0; mem_we = 0;
    @(posedge clk); #1;
    checkOutput("hold_in_ready_2", in_ready, 0);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    checkOutput("hold_release_valid", out_valid, 0);

    // Flush kills the held beat and discards the incoming one.
    out_ready = 0;
    applyStimulus(mk(32'h300, 32'hA, 32'hB, 32'h0, 2, 3, 5, 4'b0111, 0, 0), 32'hA, 32'hB, 32'hB, 0);
    in_pc = 32'h304; in_rs1_data = 32'hEE; in_rd_addr = 6;
    flush = 1;
    #1;
    checkOutput("flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    checkOutput("flush_out_valid", out_valid, 0);
    out_ready = 1;
    idleCycles(3);
    checkOutput("flush_still_empty", out_valid, 0);

    // Back-to-back stream of eight.
    startN = consCyc.size();
    for (int i = 0; i < 8; i++)
      applyStimulus(mk(32'h500 + 4*i, 32'h1000 + i, 32'h2000 + i, 32'h0, 1, 2, RA_W'(i), 4'(i), 0, 0),
                    32'h1000 + i, 32'h2000 + i, 32'h2000 + i, 1);
    idleCycles(1);
    checkOutput("stream_count", consCyc.size() - startN, 8);
    if (consCyc.size() - startN == 8)
      checkOutput("stream_span", consCyc[consCyc.size()-1] - consCyc[startN], 7);

    // Reset mid-stream: the held beat is lost.
    applyStimulus(mk(32'h600, 32'h61, 32'h62, 32'h0, 1, 2, 7, 4'b1000, 0, 0), 32'h61, 32'h62, 32'h62, 1);
    applyStimulus(mk(32'h604, 32'h71, 32'h72, 32'h0, 1, 2, 8, 4'b1001, 0, 0), 32'h71, 32'h72, 32'h72, 1);
    in_valid = 0;
    rst_n = 0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_srca", SrcA, 0);
    checkOutput("midreset_alu", ALUcontrol, 0);
    expQ.delete();
    #2;
    rst_n = 1;
    idleCycles(3);
    checkOutput("midreset_stays_empty", out_valid, 0);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
